led_strip_tx: RTL and testbench

Serial output stage for the LED strip controller. It takes the parallel 10-pixel strip word and the 3-bit brightness produced by the strip/mode/colour logic. It scales every pixel by brightness and streams the frame, MSB-first in GRB order, as a single-wire WS2812-style pulse-width-coded waveform. A latch (reset) gap follows each frame. It sits between the controller's `strip`/`brightness` outputs and the physical data pin.

---
 rtl/led_pkg.sv | 27 ++
 rtl/led_strip_tx_brightness_scaler.sv | 26 ++
 rtl/led_strip_tx.sv | 149 ++++++++++++++
 tb/tb_led_strip_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and default timing for the LED strip serial transmitter.
package led_pkg;

  localparam int PIXEL_W  = 24;
  localparam int BRIGHT_W = 3;

  localparam int NUM_LEDS_DEF  = 10;
  localparam int T0H_DEF       = 20;
  localparam int T1H_DEF       = 40;
  localparam int T_BIT_DEF     = 63;
  localparam int RESET_CYC_DEF = 2800;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [NUM_LEDS_DEF-1:0] strip_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT_HI,
    S_BIT_LO,
    S_LATCH
  } tx_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_strip_tx_brightness_scaler.sv
// Combinational brightness scaling of one RGB pixel, returned in GRB wire order.
module brightness_scaler
  import led_pkg::*;
(
  input  pixel_t              pixel,
  input  logic [BRIGHT_W-1:0] brightness,
  output pixel_t              grb
);

  logic [3:0]  factor;
  logic [23:0] scaled;

  assign factor = {1'b0, brightness} + 4'd1;

  // Channel gi: 0 = B, 1 = G, 2 = R; keep product bits [10:3], truncating.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [10:0] prod;
      assign prod = {3'b000, pixel[gi*8 +: 8]} * {7'b0000000, factor};
      assign scaled[gi*8 +: 8] = prod[10:3];
    end
  endgenerate

  assign grb = {scaled[15:8], scaled[23:16], scaled[7:0]};

endmodule

// File: rtl/led_strip_tx.sv
// WS2812-style single-wire transmitter: snapshots a strip frame, scales it and
// streams it MSB-first in GRB order, followed by a latch gap.
module led_strip_tx
  import led_pkg::*;
#(
  parameter int NUM_LEDS  = NUM_LEDS_DEF,
  parameter int T0H       = T0H_DEF,
  parameter int T1H       = T1H_DEF,
  parameter int T_BIT     = T_BIT_DEF,
  parameter int RESET_CYC = RESET_CYC_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_LEDS-1:0][23:0]      strip,
  input  logic [BRIGHT_W-1:0]            brightness,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           dout
);

  localparam int CYC_W = $clog2(max2(T_BIT, RESET_CYC) + 1);
  localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CYC_W-1:0] T0H_LAST   = CYC_W'(T0H - 1);
  localparam logic [CYC_W-1:0] T1H_LAST   = CYC_W'(T1H - 1);
  localparam logic [CYC_W-1:0] T_BIT_LAST = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] RST_LAST   = CYC_W'(RESET_CYC - 1);
  localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(NUM_LEDS - 1);

  tx_state_e                  state_q, state_d;
  logic [CYC_W-1:0]           cyc_q, cyc_d;
  logic [4:0]                 bit_q, bit_d;
  logic [PIX_W-1:0]           pix_q, pix_d;
  logic [NUM_LEDS-1:0][23:0]  snap_q, snap_d;
  logic [BRIGHT_W-1:0]        bright_q, bright_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       dout_q, dout_d;

  pixel_t grb_cur;
  logic   bit_val;

  brightness_scaler u_scaler (
    .pixel      (snap_q[pix_q]),
    .brightness (bright_q),
    .grb        (grb_cur)
  );

  assign bit_val = grb_cur[bit_q];

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    pix_d    = pix_q;
    snap_d   = snap_q;
    bright_d = bright_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d   = strip;
          bright_d = brightness;
          cyc_d    = '0;
          bit_d    = 5'd23;
          pix_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_BIT_HI;
        end
      end

      S_BIT_HI: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == (bit_val ? T1H_LAST : T0H_LAST)) begin
          state_d = S_BIT_LO;
        end
      end

      // The cycle counter runs across both halves so the bit totals T_BIT.
      S_BIT_LO: begin
        if (cyc_q == T_BIT_LAST) begin
          cyc_d = '0;
          if (bit_q == 5'd0) begin
            if (pix_q == PIX_LAST) begin
              state_d = S_LATCH;
            end else begin
              pix_d   = pix_q + PIX_W'(1);
              bit_d   = 5'd23;
              state_d = S_BIT_HI;
            end
          end else begin
            bit_d   = bit_q - 5'd1;
            state_d = S_BIT_HI;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      S_LATCH: begin
        if (cyc_q == RST_LAST) begin
          cyc_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so dout lines up with the phase it encodes.
    dout_d = (state_d == S_BIT_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      pix_q    <= '0;
      snap_q   <= '0;
      bright_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      pix_q    <= pix_d;
      snap_q   <= snap_d;
      bright_q <= bright_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_led_strip_tx.sv
// Self-checking bench for led_strip_tx against a per-bit waveform model.
module tb_led_strip_tx;

  localparam int NL  = 2;
  localparam int T0H = 2;
  localparam int T1H = 4;
  localparam int TB  = 6;
  localparam int RC  = 10;

  logic                clk;
  logic                rst_n;
  logic [NL-1:0][23:0] strip;
  logic [2:0]          brightness;
  logic                start;
  logic                busy;
  logic                done;
  logic                dout;

  int n_tests = 0;
  int n_fail  = 0;

  led_strip_tx #(
    .NUM_LEDS  (NL),
    .T0H       (T0H),
    .T1H       (T1H),
    .T_BIT     (TB),
    .RESET_CYC (RC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .strip      (strip),
    .brightness (brightness),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: channel * (level+1) / 8, then wire order G,R,B.
  function automatic logic [23:0] model_grb(input logic [23:0] px, input int b);
    int r, g, bl;
    r  = (int'(px[23:16]) * (b + 1)) / 8;
    g  = (int'(px[15:8])  * (b + 1)) / 8;
    bl = (int'(px[7:0])   * (b + 1)) / 8;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1, input int b,
                           input bit mid_change, input bit late_start, input bit hold,
                           input int abort_at);
    logic [23:0]   g [NL];
    logic [TB-1:0] obs, expv;
    int busy_lo, lat_bad, idle_bad, bidx, ci, px, bn, h, waited;
    g[0] = model_grb(p0, b);
    g[1] = model_grb(p1, b);
    strip[0] = p0;
    strip[1] = p1;
    brightness = 3'(b);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    busy_lo = 0;
    obs = '0;
    for (int i = 0; i < NL * 24 * TB; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_dout", 32'(dout), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      bidx = i / TB;
      ci   = i % TB;
      obs[ci] = dout;
      if (!busy) busy_lo++;
      if (mid_change && i == 3 * TB) strip[1] = 24'h00FF00;
      if (late_start && i == 100) start = 1'b1;
      if (late_start && i == 101) start = 1'b0;
      if (ci == TB - 1) begin
        px = bidx / 24;
        bn = 23 - (bidx % 24);
        h  = g[px][bn] ? T1H : T0H;
        expv = '0;
        for (int c = 0; c < h; c++) expv[c] = 1'b1;
        $display("[TB] px%0d bit%0d dout=%b exp=%b", px, bn, obs, expv);
        check($sformatf("px%0d_bit%0d", px, bn), 32'(obs), 32'(expv));
      end
    end
    check("busy_during_bits", busy_lo, 0);
    lat_bad = 0;
    for (int i = 0; i < RC; i++) begin
      @(negedge clk);
      if (dout || done || !busy) lat_bad++;
    end
    check("latch_gap", lat_bad, 0);
    @(negedge clk);
    check("done_at_298", 32'(done), 1);
    check("busy_fall_with_done", 32'(busy), 0);
    check("dout_at_done", 32'(dout), 0);
    if (hold) begin
      @(negedge clk);
      check("b2b_busy", 32'(busy), 1);
      check("b2b_dout", 32'(dout), 1);
      start = 1'b0;
      waited = 0;
      while (!done && waited < 1000) begin
        @(negedge clk);
        waited++;
      end
      check("b2b_second_done", 32'(done), 1);
    end else begin
      idle_bad = 0;
      @(negedge clk);
      check("done_one_cycle", 32'(done), 0);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (busy || dout || done) idle_bad++;
      end
      check(late_start ? "no_queued_frame" : "idle_after_frame", idle_bad, 0);
    end
  endtask

  initial begin
    int idle_bad;
    rst_n = 1'b0;
    start = 1'b0;
    strip = '0;
    brightness = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", 32'(dout), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dout || busy || done) idle_bad++;
    end
    check("idle_no_start", idle_bad, 0);

    run_frame(24'hFF0000, 24'h0000FF, 7, 0, 0, 0, -1);
    run_frame(24'hFFFFFF, 24'hFFFFFF, 0, 0, 0, 0, -1);
    run_frame(24'h123456, 24'h00FF00, 5, 1, 1, 0, -1);
    for (int r = 0; r < 4; r++) begin
      run_frame(24'($urandom), 24'($urandom), int'($urandom_range(0, 7)), 0, 0, 0, -1);
    end
    run_frame(24'($urandom), 24'($urandom), int'($urandom_range(0, 7)), 0, 0, 1, -1);
    run_frame(24'hA5C3F0, 24'h5A3C0F, 6, 0, 0, 0, (24 + 18) * TB + 1);
    run_frame(24'hA5C3F0, 24'h5A3C0F, 6, 0, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
